fifo_burst_drain_ctl: RTL

- Read-side scheduler for the team's synchronous block-RAM FIFO (RE/DO/ACK/EF/Cnt interface, 1-cycle read latency).
- Drains the FIFO in bursts onto a valid/ready stream.
- Starts a full burst when the FIFO holds at least BurstLen words, or a partial flush after Timeout idle cycles with data present.
- Marks the last word of every burst with TLAST. Sits between the FIFO and a packetising transmitter.

---
 rtl/fifo_burst_drain_ctl_pkg.sv | 19 +
 rtl/fifo_burst_drain_ctl_if.sv | 26 ++
 rtl/fifo_skid2.sv | 64 ++++++
 rtl/fifo_burst_drain_ctl.sv | 104 ++++++++++
 4 files changed

// File: rtl/fifo_burst_drain_ctl_pkg.sv
// Shared types for the FIFO burst-drain scheduler: FSM state encoding and the
// burst-length clamp helper.
package fifo_burst_drain_ctl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDrain = 2'd2
  } state_e;

  // A length of 0 means a single word; anything above the FIFO depth is capped there.
  function automatic int unsigned clamp_burst_len(input int unsigned len,
                                                  input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/fifo_burst_drain_ctl_if.sv
// FIFO read port plus valid/ready output stream of the burst-drain scheduler.
// master = the scheduler, slave = FIFO and downstream transmitter.
interface fifo_burst_drain_ctl_if #(
  parameter int unsigned pAddr  = 10,
  parameter int unsigned pWidth = 8
);
  logic              FIFO_RE;
  logic [pWidth-1:0] FIFO_DO;
  logic              FIFO_ACK;
  logic              FIFO_EF;
  logic [pAddr:0]    FIFO_Cnt;
  logic              TVLD;
  logic [pWidth-1:0] TDAT;
  logic              TLAST;
  logic              TRDY;

  modport master (
    output FIFO_RE, TVLD, TDAT, TLAST,
    input  FIFO_DO, FIFO_ACK, FIFO_EF, FIFO_Cnt, TRDY
  );

  modport slave (
    input  FIFO_RE, TVLD, TDAT, TLAST,
    output FIFO_DO, FIFO_ACK, FIFO_EF, FIFO_Cnt, TRDY
  );
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry output buffer. The head is always a register, so nothing downstream
// sees a combinational path from pop to head.
module fifo_skid2 #(
  parameter int unsigned pWidth = 9
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              push,
  input  logic [pWidth-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [pWidth-1:0] head
);
  logic [pWidth-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        occ_q, occ_d;
  logic              do_pop;

  assign do_pop = pop && (occ_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_d  = push_data;
          occ_d = 2'd1;
        end else if (occ_q == 2'd1) begin
          e1_d  = push_data;
          occ_d = 2'd2;
        end
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;
endmodule

// File: rtl/fifo_burst_drain_ctl.sv
// Read-side scheduler: drains the block-RAM FIFO in TLAST-terminated bursts,
// either full-length or as a partial flush after an idle timeout.
module fifo_burst_drain_ctl
  import fifo_burst_drain_ctl_pkg::*;
#(
  parameter int unsigned pAddr  = 10,
  parameter int unsigned pWidth = 8,
  parameter int unsigned pTOW   = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   En,
  input  logic [pAddr:0]         BurstLen,
  input  logic [pTOW-1:0]        Timeout,
  output logic                   Busy,
  fifo_burst_drain_ctl_if.master bus
);
  localparam int unsigned CntW = pAddr + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] rem_q, rem_d;
  logic [pTOW-1:0] idle_q, idle_d;
  logic            pend_q, last_q;
  logic [CntW-1:0] burst_eff;
  logic            start_full, start_flush, pop, re;
  logic [1:0]      occ, occ_left;
  logic [pWidth:0] head;

  assign burst_eff   = CntW'(clamp_burst_len(32'(BurstLen), 32'(1) << pAddr));
  assign start_full  = En && (bus.FIFO_Cnt >= burst_eff);
  assign start_flush = En && (Timeout != '0) && !bus.FIFO_EF && (idle_q == Timeout - pTOW'(1));
  assign pop         = bus.TVLD && bus.TRDY;
  // A word leaving this cycle frees its slot, sustaining one word per cycle when TRDY stays high.
  assign occ_left    = occ - {1'b0, pop};

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_full || start_flush) state_d = StBurst;
      StBurst: if (re && (rem_q == CntW'(1))) state_d = StDrain;
      StDrain: if (!pend_q && (occ == 2'd0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    re   = (state_q == StBurst) && (rem_q != '0) && !bus.FIFO_EF
           && ((occ_left + {1'b0, pend_q}) < 2'd2);
    Busy = (state_q != StIdle);
  end

  always_comb begin
    rem_d  = rem_q;
    idle_d = idle_q;
    if (state_q == StIdle) begin
      if (start_full)       rem_d = burst_eff;
      else if (start_flush) rem_d = bus.FIFO_Cnt;
      if (bus.FIFO_EF || (state_d != StIdle)) begin
        idle_d = '0;
      end else if ((bus.FIFO_Cnt < burst_eff) && (idle_q != '1)) begin
        idle_d = idle_q + pTOW'(1);
      end
    end else if (re) begin
      rem_d = rem_q - CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rem_q  <= '0;
      idle_q <= '0;
      pend_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      idle_q <= idle_d;
      pend_q <= re;
      // Travels with the outstanding read so its ACK lands tagged as last.
      last_q <= re && (rem_q == CntW'(1));
    end
  end

  fifo_skid2 #(
    .pWidth (pWidth + 1)
  ) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (bus.FIFO_ACK),
    .push_data ({last_q, bus.FIFO_DO}),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign bus.FIFO_RE = re;
  assign bus.TVLD    = (occ != 2'd0);
  assign bus.TDAT    = head[pWidth-1:0];
  assign bus.TLAST   = head[pWidth] && (occ != 2'd0);
endmodule
